// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types and constants for the uP register bus sequencer.
// State/error enums, command codes and reply status packing.
package reg_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACCESS,
    REPLY
  } seq_state_t;

  typedef enum logic [7:0] {
    OK       = 8'd0,
    BAD_CMD  = 8'd1,
    BAD_ADDR = 8'd2,
    TIMEOUT  = 8'd3,
    BUS_ERR  = 8'd4
  } err_code_t;

  localparam logic [7:0] READ_REGISTER_CMD  = 8'd0;
  localparam logic [7:0] WRITE_REGISTER_CMD = 8'd1;

  localparam int ST_ERR_LSB  = 0;
  localparam int ST_CMD_LSB  = 8;
  localparam int ST_ADDR_LSB = 16;
  localparam int ST_SEQ_LSB  = 24;

  typedef struct packed {
    logic [7:0]  code;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  function automatic logic [31:0] pack_status(
    input err_code_t  err,
    input logic [7:0] code,
    input logic [7:0] addr,
    input logic [7:0] seq
  );
    logic [31:0] s;
    s = '0;
    s[ST_ERR_LSB +: 8]  = err;
    s[ST_CMD_LSB +: 8]  = code;
    s[ST_ADDR_LSB +: 8] = addr;
    s[ST_SEQ_LSB +: 8]  = seq;
    return s;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_access_timer.sv
// Loadable down-counter bounding the bus ACCESS wait.
// expired is high whenever the count has run out.
module access_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/reg_bus_sequencer.sv
// Sequences one uP command into one register bus access
// and returns an 8-byte reply (data + status).
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int NOS_REGISTERS  = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [7:0]  cmd_reg_addr,
  input  logic [31:0] cmd_data,
  output logic        bus_req,
  output logic        bus_RW,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic        reply_valid,
  input  logic        reply_ready,
  output logic [31:0] reply_data,
  output logic [31:0] reply_status,
  output logic        busy
);

  // Loaded one short so expiry lands on the last allowed cycle.
  localparam logic [7:0] TMR_INIT = 8'(TIMEOUT_CYCLES - 1);

  seq_state_t  state;
  seq_state_t  state_nxt;
  cmd_t        cmd_q;
  logic [7:0]  seq_count;
  logic [31:0] rdata_q;
  logic [31:0] rstat_q;

  logic        accept;
  logic        load_reply;
  logic        done;
  err_code_t   err_nxt;
  logic [31:0] data_nxt;

  logic        code_ok;
  logic        addr_ok;
  logic        is_write;

  logic        tmr_load;
  logic        tmr_dec;
  logic        tmr_expired;

  assign is_write = (cmd_q.code == WRITE_REGISTER_CMD);
  assign code_ok  = is_write ||
                    (cmd_q.code == READ_REGISTER_CMD);
  assign addr_ok  = int'(cmd_q.addr) < NOS_REGISTERS;

  access_timer #(
    .W(8)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .clear     (done),
    .dec       (tmr_dec),
    .load_value(TMR_INIT),
    .expired   (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    load_reply = 1'b0;
    done       = 1'b0;
    err_nxt    = OK;
    data_nxt   = '0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (!code_ok) begin
          err_nxt    = BAD_CMD;
          load_reply = 1'b1;
          state_nxt  = REPLY;
        end else if (!addr_ok) begin
          err_nxt    = BAD_ADDR;
          load_reply = 1'b1;
          state_nxt  = REPLY;
        end else begin
          tmr_load  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        tmr_dec = 1'b1;
        // An ack on the expiry cycle still counts as success.
        if (bus_ack) begin
          load_reply = 1'b1;
          state_nxt  = REPLY;
          if (bus_err) begin
            err_nxt = BUS_ERR;
          end else begin
            err_nxt  = OK;
            data_nxt = is_write ? cmd_q.data : bus_rdata;
          end
        end else if (tmr_expired) begin
          err_nxt    = TIMEOUT;
          load_reply = 1'b1;
          state_nxt  = REPLY;
        end
      end
      REPLY: begin
        if (reply_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q     <= '0;
      seq_count <= '0;
      rdata_q   <= '0;
      rstat_q   <= '0;
    end else begin
      if (accept) begin
        cmd_q <= '{code: cmd_code,
                   addr: cmd_reg_addr,
                   data: cmd_data};
      end
      if (load_reply) begin
        rdata_q <= data_nxt;
        rstat_q <= pack_status(err_nxt, cmd_q.code,
                               cmd_q.addr, seq_count);
      end
      if (done) begin
        seq_count <= seq_count + 8'd1;
      end
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign bus_req      = (state == ACCESS);
  assign bus_RW       = is_write;
  assign bus_addr     = cmd_q.addr;
  assign bus_wdata    = cmd_q.data;
  assign reply_valid  = (state == REPLY);
  assign reply_data   = rdata_q;
  assign reply_status = rstat_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Timeline-model bench for reg_bus_sequencer: every edge's
// inputs and expected outputs are scheduled up front.
module tb_reg_bus_sequencer;

  localparam int MAXE = 16384;
  localparam int MAXT = 512;
  localparam int TMO  = 255;
  localparam int NREG = 64;
  localparam logic [7:0] PWM_0      = 8'h10;
  localparam logic [7:0] PWM_PERIOD = 8'h01;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_reg_addr;
  logic [31:0] cmd_data;
  logic        bus_req;
  logic        bus_RW;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        reply_valid;
  logic        reply_ready;
  logic [31:0] reply_data;
  logic [31:0] reply_status;
  logic        busy;

  reg_bus_sequencer #(
    .NOS_REGISTERS (NREG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_code    (cmd_code),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_data    (cmd_data),
    .bus_req     (bus_req),
    .bus_RW      (bus_RW),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err),
    .reply_valid (reply_valid),
    .reply_ready (reply_ready),
    .reply_data  (reply_data),
    .reply_status(reply_status),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [31:0] exp_status;
    bit          lit;
    logic [31:0] lit_data;
    logic [31:0] lit_status;
  } txn_t;

  txn_t tx [MAXT];

  bit          d_rst [MAXE];
  bit          d_cv  [MAXE];
  bit          d_ack [MAXE];
  bit          d_err [MAXE];
  bit          d_rdy [MAXE];
  logic [7:0]  d_code[MAXE];
  logic [7:0]  d_addr[MAXE];
  logic [31:0] d_data[MAXE];
  logic [31:0] d_rd  [MAXE];

  // Phase after each edge: 0 idle, 1 decode, 2 access, 3 reply.
  int x_cls[MAXE];
  int x_tid[MAXE];
  bit x_rst[MAXE];

  int         nxt;
  int         ntx;
  int         last_e;
  int         wrap_tid;
  logic [7:0] mseq;
  int         checks   = 0;
  int         failures = 0;

  task automatic fill_noise();
    for (int e = 0; e < MAXE; e++) begin
      d_rst[e]  = 1'b0;
      d_cv[e]   = 1'b0;
      d_ack[e]  = ($urandom_range(0, 5) == 0);
      d_err[e]  = 1'($urandom_range(0, 1));
      d_rdy[e]  = ($urandom_range(0, 2) == 0);
      d_code[e] = 8'($urandom);
      d_addr[e] = 8'($urandom);
      d_data[e] = $urandom;
      d_rd[e]   = $urandom;
      x_cls[e]  = 0;
      x_tid[e]  = -1;
      x_rst[e]  = 1'b0;
    end
    for (int e = 0; e < 4; e++) begin
      d_rst[e] = 1'b1;
      x_rst[e] = 1'b1;
    end
    nxt  = 4;
    ntx  = 0;
    mseq = 8'd0;
  endtask

  // j: ack in access cycle j (0 = never); rst_at: reset after
  // that many access cycles (0 = no reset).
  task automatic add_txn(
    input logic [7:0]  code,
    input logic [7:0]  addr,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input int          j,
    input bit          berr,
    input int          h,
    input int          g,
    input bit          pre,
    input int          rst_at,
    input bit          lit,
    input logic [31:0] lit_data,
    input logic [31:0] lit_status
  );
    int acc;
    int n;
    int r;
    int x;
    logic [7:0]  ecode;
    logic [31:0] edata;
    acc = nxt + g;
    if (pre && g == 0) begin
      d_cv[acc-1]   = 1'b1;
      d_code[acc-1] = code;
      d_addr[acc-1] = addr;
      d_data[acc-1] = wdata;
    end
    d_cv[acc]   = 1'b1;
    d_code[acc] = code;
    d_addr[acc] = addr;
    d_data[acc] = wdata;
    x_cls[acc]  = 1;
    x_tid[acc]  = ntx;
    tx[ntx].code       = code;
    tx[ntx].addr       = addr;
    tx[ntx].wdata      = wdata;
    tx[ntx].lit        = lit;
    tx[ntx].lit_data   = lit_data;
    tx[ntx].lit_status = lit_status;
    if (code > 8'd1) begin
      ecode = 8'd1; edata = '0; n = 0;
    end else if (int'(addr) >= NREG) begin
      ecode = 8'd2; edata = '0; n = 0;
    end else begin
      n = (j == 0) ? TMO : j;
      if (j == 0) begin
        ecode = 8'd3; edata = '0;
      end else if (berr) begin
        ecode = 8'd4; edata = '0;
      end else begin
        ecode = 8'd0;
        edata = (code == 8'd1) ? wdata : rdata;
      end
    end
    if (rst_at > 0 && n > 0) begin
      for (int k = 1; k <= rst_at; k++) begin
        x_cls[acc+k]   = 2;
        x_tid[acc+k]   = ntx;
        d_ack[acc+k+1] = 1'b0;
      end
      x = acc + rst_at + 1;
      d_rst[x] = 1'b1;
      x_rst[x] = 1'b1;
      x_cls[x] = 0;
      mseq = 8'd0;
      nxt  = x + 1;
      ntx++;
      return;
    end
    for (int k = 1; k <= n; k++) begin
      x_cls[acc+k]   = 2;
      x_tid[acc+k]   = ntx;
      d_ack[acc+k+1] = 1'b0;
    end
    if (n > 0 && j != 0) begin
      d_ack[acc+j+1] = 1'b1;
      d_err[acc+j+1] = berr;
      d_rd[acc+j+1]  = rdata;
    end
    r = acc + n + 2 + h;
    for (int e = acc + n + 1; e < r; e++) begin
      x_cls[e] = 3;
      x_tid[e] = ntx;
    end
    for (int e = acc + n + 2; e <= r; e++) d_rdy[e] = (e == r);
    tx[ntx].exp_data   = edata;
    tx[ntx].exp_status = {mseq, addr, code, ecode};
    mseq = mseq + 8'd1;
    nxt  = r + 1;
    ntx++;
  endtask

  task automatic build();
    int c;
    int j;
    int g;
    bit pre;
    logic [7:0] code;
    logic [7:0] addr;
    fill_noise();
    add_txn(8'd1, PWM_0 + PWM_PERIOD, 32'd100, $urandom,
            3, 0, 0, 1, 0, 0, 1, 32'd100, 32'h0011_0100);
    add_txn(8'd0, 8'd5, $urandom, 32'hDEAD_BEEF,
            1, 0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0105_0000);
    add_txn(8'd7, 8'd200, $urandom, $urandom,
            1, 0, 1, 2, 0, 0, 1, 32'd0, 32'h02C8_0701);
    add_txn(8'd0, 8'd64, $urandom, $urandom,
            1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h0340_0002);
    add_txn(8'd0, 8'd3, $urandom, $urandom,
            0, 0, 2, 1, 0, 0, 1, 32'd0, 32'h0403_0003);
    add_txn(8'd0, 8'd3, $urandom, 32'h1234_5678,
            255, 0, 0, 1, 0, 0, 1, 32'h1234_5678, 32'h0503_0000);
    add_txn(8'd1, 8'd9, 32'hCAFE_0001, $urandom,
            2, 1, 0, 0, 1, 0, 1, 32'd0, 32'h0609_0104);
    add_txn(8'd0, 8'd1, $urandom, 32'hA5A5_A5A5,
            1, 0, 20, 1, 0, 0, 1, 32'hA5A5_A5A5, 32'h0701_0000);
    add_txn(8'd0, 8'd2, $urandom, $urandom,
            0, 0, 0, 1, 0, 5, 0, 32'd0, 32'd0);
    add_txn(8'd0, 8'd4, $urandom, 32'h0BAD_F00D,
            1, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 32'h0004_0000);
    wrap_tid = ntx - 1 + 256;
    for (int t = 0; t < 272; t++) begin
      if (nxt > MAXE - 600) break;
      c = $urandom_range(0, 9);
      code = (c <= 8) ? 8'(c % 2) : 8'($urandom_range(2, 255));
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                         : 8'($urandom_range(0, 63));
      j   = ($urandom_range(0, 63) == 0) ? 0 : $urandom_range(1, 5);
      g   = $urandom_range(0, 2);
      pre = (g == 0) && ($urandom_range(0, 1) == 1);
      add_txn(code, addr, $urandom, $urandom, j,
              ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
              g, pre, 0, 0, 32'd0, 32'd0);
    end
    last_e = nxt + 4;
  endtask

  task automatic chk(input string nm, input int e,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h",
               nm, e, act, exp);
    end
  endtask

  task automatic check_edge(input int e);
    int c;
    int t;
    c = x_cls[e];
    t = x_tid[e];
    chk("cmd_ready", e, 32'(cmd_ready), 32'(c == 0));
    chk("busy", e, 32'(busy), 32'(c != 0));
    chk("bus_req", e, 32'(bus_req), 32'(c == 2));
    chk("reply_valid", e, 32'(reply_valid), 32'(c == 3));
    if (c == 2) begin
      chk("bus_RW", e, 32'(bus_RW), 32'(tx[t].code == 8'd1));
      chk("bus_addr", e, 32'(bus_addr), 32'(tx[t].addr));
      chk("bus_wdata", e, bus_wdata, tx[t].wdata);
    end
    if (c == 3) begin
      chk("reply_data", e, reply_data, tx[t].exp_data);
      chk("reply_status", e, reply_status, tx[t].exp_status);
      if (tx[t].lit) begin
        chk("lit_data", e, reply_data, tx[t].lit_data);
        chk("lit_status", e, reply_status, tx[t].lit_status);
      end
      if (t == wrap_tid)
        chk("seq_wrap", e, 32'(reply_status[31:24]), 32'd0);
    end
    if (x_rst[e]) begin
      chk("rst_data", e, reply_data, 32'd0);
      chk("rst_status", e, reply_status, 32'd0);
      chk("rst_addr", e, 32'(bus_addr), 32'd0);
      chk("rst_wdata", e, bus_wdata, 32'd0);
      chk("rst_rw", e, 32'(bus_RW), 32'd0);
    end
  endtask

  initial begin
    build();
    fork
      begin
        for (int e = 0; e <= last_e; e++) begin
          reset        = d_rst[e];
          cmd_valid    = d_cv[e];
          cmd_code     = d_code[e];
          cmd_reg_addr = d_addr[e];
          cmd_data     = d_data[e];
          bus_ack      = d_ack[e];
          bus_err      = d_err[e];
          bus_rdata    = d_rd[e];
          reply_ready  = d_rdy[e];
          @(posedge clk);
          @(negedge clk);
        end
      end
      begin
        for (int e = 0; e <= last_e; e++) begin
          @(posedge clk);
          #1;
          check_edge(e);
        end
      end
    join
    if (ntx <= wrap_tid) begin
      failures++;
      $display("FAIL wrap_reach got=%0d want=%0d", ntx, wrap_tid + 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
